mac_acc_stream: RTL and testbench

//  Streaming multiply-accumulate: unsigned A x B split into TILE_A x TILE_B DSP tiles, partial products

---
 rtl/mac_acc_stream_if.sv | 30 +++
 rtl/mac_acc_stream.sv | 193 +++++++++++++++++++
 tb/tb_mac_acc_stream.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mac_acc_stream_if.sv
// Stream bundle for mac_acc_stream: operand beats in, group results out, each with valid/ready.
interface mac_acc_stream_if #(
    parameter int LOGA   = 60,
    parameter int LOGB   = 60,
    parameter int LOGACC = 128,
    parameter int LOGN   = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [LOGA-1:0]   in_a;
    logic [LOGB-1:0]   in_b;
    logic              in_sub;
    logic              in_first;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [LOGACC-1:0] out_data;
    logic [LOGN-1:0]   out_beats;
    logic              out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_sub, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_beats, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_first, in_last, out_ready,
        output in_ready, out_valid, out_data, out_beats, out_ovf
    );
endinterface

// File: rtl/mac_acc_stream.sv
// Streaming MAC: tiled unsigned A*B, signed per-group accumulate with add/sub, 4-stage stallable pipe.
// Optional MAC_ACC_SAT_EN: accumulator saturates on signed overflow instead of wrapping.
module mac_acc_stream #(
    parameter int LOGA   = 60,
    parameter int LOGB   = 60,
    parameter int TILE_A = 24,
    parameter int TILE_B = 17,
    parameter int LOGACC = 128,
    parameter int LOGN   = 8
) (
    input logic clk,
    input logic rst,
    mac_acc_stream_if.slave s_if
);
    localparam int NA  = (LOGA + TILE_A - 1) / TILE_A;
    localparam int NB  = (LOGB + TILE_B - 1) / TILE_B;
    localparam int APW = NA * TILE_A;
    localparam int BPW = NB * TILE_B;
    localparam int TW  = TILE_A + TILE_B;
    localparam int PW  = LOGA + LOGB;
    localparam int SW  = APW + BPW;
    localparam int MSB = LOGACC - 1;

    logic stall;
    logic outValid_q;

    assign stall       = outValid_q & ~s_if.out_ready;
    assign s_if.in_ready = ~stall;

    // S1: operand and flag capture
    logic            s1Valid_q, s1Sub_q, s1First_q, s1Last_q;
    logic [LOGA-1:0] s1A_q;
    logic [LOGB-1:0] s1B_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Valid_q <= 1'b0;
            s1Sub_q   <= 1'b0;
            s1First_q <= 1'b0;
            s1Last_q  <= 1'b0;
            s1A_q     <= '0;
            s1B_q     <= '0;
        end else if (!stall) begin
            s1Valid_q <= s_if.in_valid;
            s1Sub_q   <= s_if.in_sub;
            s1First_q <= s_if.in_first;
            s1Last_q  <= s_if.in_last;
            s1A_q     <= s_if.in_a;
            s1B_q     <= s_if.in_b;
        end
    end

    // S2: one product register per (A tile, B tile) pair; operands zero-padded to whole tiles
    logic [APW-1:0] aPad;
    logic [BPW-1:0] bPad;
    logic [TW-1:0]  tile_d [NA][NB];
    logic [TW-1:0]  tile_q [NA][NB];
    logic           s2Valid_q, s2Sub_q, s2First_q, s2Last_q;

    assign aPad = APW'(s1A_q);
    assign bPad = BPW'(s1B_q);

    always_comb begin
        for (int i = 0; i < NA; i++) begin
            for (int j = 0; j < NB; j++) begin
                tile_d[i][j] = TW'(aPad[i*TILE_A +: TILE_A]) * TW'(bPad[j*TILE_B +: TILE_B]);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Valid_q <= 1'b0;
            s2Sub_q   <= 1'b0;
            s2First_q <= 1'b0;
            s2Last_q  <= 1'b0;
            for (int i = 0; i < NA; i++) begin
                for (int j = 0; j < NB; j++) begin
                    tile_q[i][j] <= '0;
                end
            end
        end else if (!stall) begin
            s2Valid_q <= s1Valid_q;
            s2Sub_q   <= s1Sub_q;
            s2First_q <= s1First_q;
            s2Last_q  <= s1Last_q;
            for (int i = 0; i < NA; i++) begin
                for (int j = 0; j < NB; j++) begin
                    tile_q[i][j] <= tile_d[i][j];
                end
            end
        end
    end

    // S3: recombine tiles at their bit offsets; padding bits are zero so the sum fits in PW
    logic [SW-1:0] prodSum;
    logic [PW-1:0] s3Prod_q;
    logic          s3Valid_q, s3Sub_q, s3First_q, s3Last_q;

    always_comb begin
        prodSum = '0;
        for (int i = 0; i < NA; i++) begin
            for (int j = 0; j < NB; j++) begin
                prodSum = prodSum + (SW'(tile_q[i][j]) << (i*TILE_A + j*TILE_B));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3Valid_q <= 1'b0;
            s3Sub_q   <= 1'b0;
            s3First_q <= 1'b0;
            s3Last_q  <= 1'b0;
            s3Prod_q  <= '0;
        end else if (!stall) begin
            s3Valid_q <= s2Valid_q;
            s3Sub_q   <= s2Sub_q;
            s3First_q <= s2First_q;
            s3Last_q  <= s2Last_q;
            s3Prod_q  <= PW'(prodSum);
        end
    end

    // S4: signed accumulate; a closed group makes the next beat start from zero even without in_first
    logic [LOGACC-1:0] acc_q, prodAcc, base, stepRes, acc_d, outData_q;
    logic [LOGN-1:0]   cnt_q, cnt_d, outBeats_q;
    logic              ovf_q, ovf_d, outOvf_q, closed_q, newGroup, stepOvf;

    assign prodAcc  = LOGACC'(s3Prod_q);
    assign newGroup = s3First_q | closed_q;
    assign base     = newGroup ? '0 : acc_q;

    always_comb begin
        if (s3Sub_q) begin
            stepRes = base - prodAcc;
            stepOvf = (base[MSB] != prodAcc[MSB]) && (stepRes[MSB] != base[MSB]);
        end else begin
            stepRes = base + prodAcc;
            stepOvf = (base[MSB] == prodAcc[MSB]) && (stepRes[MSB] != base[MSB]);
        end
`ifdef MAC_ACC_SAT_EN
        if (stepOvf) begin
            acc_d = s3Sub_q ? {1'b1, {(LOGACC-1){1'b0}}} : {1'b0, {(LOGACC-1){1'b1}}};
        end else begin
            acc_d = stepRes;
        end
`else
        acc_d = stepRes;
`endif
        if (newGroup) begin
            cnt_d = LOGN'(1);
        end else if (cnt_q == {LOGN{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + LOGN'(1);
        end
        ovf_d = (newGroup ? 1'b0 : ovf_q) | stepOvf;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            closed_q   <= 1'b0;
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outBeats_q <= '0;
            outOvf_q   <= 1'b0;
        end else if (!stall) begin
            if (s3Valid_q) begin
                acc_q    <= acc_d;
                cnt_q    <= cnt_d;
                ovf_q    <= ovf_d;
                closed_q <= s3Last_q;
            end
            if (s3Valid_q && s3Last_q) begin
                outValid_q <= 1'b1;
                outData_q  <= acc_d;
                outBeats_q <= cnt_d;
                outOvf_q   <= ovf_d;
            end else begin
                outValid_q <= 1'b0;
            end
        end
    end

    assign s_if.out_valid = outValid_q;
    assign s_if.out_data  = outData_q;
    assign s_if.out_beats = outBeats_q;
    assign s_if.out_ovf   = outOvf_q;
endmodule

// File: tb/tb_mac_acc_stream.sv
// Directed bench for mac_acc_stream: a default 60x60/128 instance and an 8x8/8 instance for overflow paths.
module tb_mac_acc_stream;
    logic clk;
    logic rst;
    int   checkCount = 0;
    int   passCount  = 0;

    mac_acc_stream_if #(.LOGA(60), .LOGB(60), .LOGACC(128), .LOGN(8)) mIf ();
    mac_acc_stream_if #(.LOGA(8),  .LOGB(8),  .LOGACC(8),   .LOGN(2)) sIf ();

    mac_acc_stream #(.LOGA(60), .LOGB(60), .TILE_A(24), .TILE_B(17), .LOGACC(128), .LOGN(8)) dutMain (
        .clk  (clk),
        .rst  (rst),
        .s_if (mIf)
    );

    mac_acc_stream #(.LOGA(8), .LOGB(8), .TILE_A(24), .TILE_B(17), .LOGACC(8), .LOGN(2)) dutSmall (
        .clk  (clk),
        .rst  (rst),
        .s_if (sIf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MAC_ACC_SAT_EN
    localparam logic [127:0] SMALL_ADD_OVF = 128'h7F;
    localparam logic [127:0] SMALL_SUB_OVF = 128'h80;
`else
    localparam logic [127:0] SMALL_ADD_OVF = 128'hC8;
    localparam logic [127:0] SMALL_SUB_OVF = 128'h38;
`endif

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Present one beat at a falling edge; it is taken at the following rising edge.
    task automatic applyStimulus(input bit sel, input logic [59:0] a, input logic [59:0] b,
                                 input bit sub, input bit first, input bit last);
        if (sel) begin
            sIf.in_valid = 1'b1; sIf.in_a = a[7:0]; sIf.in_b = b[7:0];
            sIf.in_sub = sub; sIf.in_first = first; sIf.in_last = last;
        end else begin
            mIf.in_valid = 1'b1; mIf.in_a = a; mIf.in_b = b;
            mIf.in_sub = sub; mIf.in_first = first; mIf.in_last = last;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        mIf.in_valid = 1'b0; mIf.in_first = 1'b0; mIf.in_last = 1'b0; mIf.in_sub = 1'b0;
        sIf.in_valid = 1'b0; sIf.in_first = 1'b0; sIf.in_last = 1'b0; sIf.in_sub = 1'b0;
    endtask

    task automatic waitResult(input bit sel);
        int n = 0;
        while (!(sel ? sIf.out_valid : mIf.out_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("result arrives", {127'd0, sel ? sIf.out_valid : mIf.out_valid}, 128'd1);
    endtask

    initial begin
        logic [127:0] bigSq;
        logic [127:0] order [4];
        int           idx;

        rst = 1'b1;
        idle();
        mIf.in_a = '0; mIf.in_b = '0; mIf.out_ready = 1'b1;
        sIf.in_a = '0; sIf.in_b = '0; sIf.out_ready = 1'b1;
        #1;
        checkOutput("reset out_valid", {127'd0, mIf.out_valid}, 128'd0);
        checkOutput("reset out_data", mIf.out_data, 128'd0);
        checkOutput("reset out_beats", {120'd0, mIf.out_beats}, 128'd0);
        checkOutput("reset out_ovf", {127'd0, mIf.out_ovf}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("in_ready after reset", {127'd0, mIf.in_ready}, 128'd1);

        $display("[TB] two-beat add group and latency");
        applyStimulus(0, 60'd3, 60'd5, 0, 1, 0);
        applyStimulus(0, 60'd7, 60'd11, 0, 0, 1);
        idle();
        repeat (2) @(negedge clk);
        checkOutput("t1 not early", {127'd0, mIf.out_valid}, 128'd0);
        @(negedge clk);
        checkOutput("t1 valid at +4", {127'd0, mIf.out_valid}, 128'd1);
        checkOutput("t1 data", mIf.out_data, 128'd92);
        checkOutput("t1 beats", {120'd0, mIf.out_beats}, 128'd2);
        checkOutput("t1 ovf", {127'd0, mIf.out_ovf}, 128'd0);
        @(negedge clk);
        checkOutput("t1 consumed", {127'd0, mIf.out_valid}, 128'd0);

        $display("[TB] add then subtract to negative");
        applyStimulus(0, 60'd10, 60'd10, 0, 1, 0);
        applyStimulus(0, 60'd4, 60'd30, 1, 0, 1);
        idle();
        waitResult(0);
        checkOutput("t2 data", mIf.out_data, ~128'd19);
        checkOutput("t2 beats", {120'd0, mIf.out_beats}, 128'd2);
        @(negedge clk);

        $display("[TB] full-width operands across tile edges");
        bigSq = (128'd1 << 120) - (128'd1 << 61) + 128'd1;
        applyStimulus(0, {60{1'b1}}, {60{1'b1}}, 0, 1, 1);
        applyStimulus(0, {60{1'b1}}, 60'd1, 0, 1, 1);
        applyStimulus(0, {60{1'b1}}, {60{1'b1}}, 1, 1, 1);
        idle();
        waitResult(0);
        checkOutput("t3 max square", mIf.out_data, bigSq);
        checkOutput("t3 beats", {120'd0, mIf.out_beats}, 128'd1);
        @(negedge clk);
        checkOutput("t3 times one", mIf.out_data, 128'hFFF_FFFF_FFFF_FFFF);
        @(negedge clk);
        checkOutput("t3 negated square", mIf.out_data, ~bigSq + 128'd1);
        checkOutput("t3 neg ovf", {127'd0, mIf.out_ovf}, 128'd0);
        @(negedge clk);

        $display("[TB] backpressure with three groups in flight");
        mIf.out_ready = 1'b0;
        applyStimulus(0, 60'd1, 60'd2, 0, 1, 1);
        applyStimulus(0, 60'd3, 60'd4, 0, 1, 1);
        applyStimulus(0, 60'd5, 60'd6, 0, 1, 1);
        idle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t4 in_ready stalled", {127'd0, mIf.in_ready}, 128'd0);
            checkOutput("t4 data held", mIf.out_data, 128'd2);
        end
        mIf.out_ready = 1'b1;
        order[0] = 128'd2; order[1] = 128'd12; order[2] = 128'd30; order[3] = 128'hDEAD;
        idx = 0;
        for (int k = 0; k < 12; k++) begin
            if (mIf.out_valid) begin
                checkOutput("t4 order", mIf.out_data, order[idx < 4 ? idx : 3]);
                idx++;
            end
            @(negedge clk);
        end
        checkOutput("t4 result count", 128'(idx), 128'd3);

        $display("[TB] narrow accumulator overflow and group handling");
        applyStimulus(1, 60'd100, 60'd1, 0, 1, 0);
        applyStimulus(1, 60'd100, 60'd1, 0, 0, 1);
        idle();
        waitResult(1);
        checkOutput("t5 add overflow data", {120'd0, sIf.out_data}, SMALL_ADD_OVF);
        checkOutput("t5 add ovf", {127'd0, sIf.out_ovf}, 128'd1);
        checkOutput("t5 beats", {126'd0, sIf.out_beats}, 128'd2);
        @(negedge clk);
        applyStimulus(1, 60'd1, 60'd1, 0, 1, 1);
        applyStimulus(1, 60'd5, 60'd1, 0, 0, 1);
        idle();
        waitResult(1);
        checkOutput("t5 ovf cleared", {127'd0, sIf.out_ovf}, 128'd0);
        checkOutput("t5 single data", {120'd0, sIf.out_data}, 128'd1);
        @(negedge clk);
        checkOutput("t5 closed group restart", {120'd0, sIf.out_data}, 128'd5);
        @(negedge clk);
        applyStimulus(1, 60'd1, 60'd1, 0, 1, 0);
        repeat (3) applyStimulus(1, 60'd1, 60'd1, 0, 0, 0);
        applyStimulus(1, 60'd1, 60'd1, 0, 0, 1);
        idle();
        waitResult(1);
        checkOutput("t5 five-beat data", {120'd0, sIf.out_data}, 128'd5);
        checkOutput("t5 beats saturate", {126'd0, sIf.out_beats}, 128'd3);
        @(negedge clk);
        applyStimulus(1, 60'd100, 60'd1, 1, 1, 0);
        applyStimulus(1, 60'd100, 60'd1, 1, 0, 1);
        idle();
        waitResult(1);
        checkOutput("t5 sub overflow data", {120'd0, sIf.out_data}, SMALL_SUB_OVF);
        checkOutput("t5 sub ovf", {127'd0, sIf.out_ovf}, 128'd1);
        @(negedge clk);

        $display("[TB] reset in the middle of a group");
        applyStimulus(0, 60'd7, 60'd1, 0, 1, 1);
        applyStimulus(0, 60'd2, 60'd2, 0, 1, 0);
        applyStimulus(0, 60'd3, 60'd3, 0, 0, 0);
        idle();
        @(negedge clk);
        checkOutput("t6 pre-reset valid", {127'd0, mIf.out_valid}, 128'd1);
        checkOutput("t6 pre-reset data", mIf.out_data, 128'd7);
        #1 rst = 1'b1;
        #1;
        checkOutput("t6 valid cleared async", {127'd0, mIf.out_valid}, 128'd0);
        checkOutput("t6 data cleared", mIf.out_data, 128'd0);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(0, 60'd2, 60'd3, 0, 1, 1);
        idle();
        waitResult(0);
        checkOutput("t6 post-reset data", mIf.out_data, 128'd6);
        checkOutput("t6 post-reset beats", {120'd0, mIf.out_beats}, 128'd1);
        @(negedge clk);
        repeat (6) begin
            @(negedge clk);
            checkOutput("t6 no stray result", {127'd0, mIf.out_valid}, 128'd0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
